// File: rtl/vpu_pkg.sv
// Shared types for the VPU epilogue sequencer: pathway modes, FSM states and
// the legal-mode predicate used when a command is accepted.
package vpu_pkg;

  typedef enum logic [3:0] {
    MODE_FWD        = 4'b0000,
    MODE_LRELU      = 4'b0100,
    MODE_BIAS       = 4'b1000,
    MODE_BIAS_LRELU = 4'b1100
  } vpu_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_START,
    S_RUN,
    S_FIN
  } seq_state_e;

  function automatic logic is_legal_mode(input logic [3:0] mode);
    return (mode == MODE_BIAS_LRELU) || (mode == MODE_BIAS) ||
           (mode == MODE_LRELU) || (mode == MODE_FWD);
  endfunction

endpackage

// File: rtl/vpu_lane_ctr.sv
// Per-lane output counter: counts valids while enabled, saturating at the
// target row count, and flags when the target has been reached.
module vpu_lane_ctr #(
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic [ROW_W-1:0] target_i,
  output logic             reached_o
);

  logic [ROW_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && inc_i && (count_q != target_i)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign reached_o = (count_q == target_i);

endmodule

// File: rtl/vpu_seq.sv
// Layer-epilogue sequencer: fetches per-column bias from the UB when needed,
// drives VPU operands, starts the systolic array and tracks per-lane completion.
module vpu_seq
  import vpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int ROW_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_mode,
  input  logic [ROW_W-1:0]    cmd_rows,
  input  logic [ADDR_W-1:0]   cmd_bias_addr,
  input  logic [DATA_W-1:0]   cmd_leak,
  output logic                ub_rd_req,
  output logic [ADDR_W-1:0]   ub_rd_addr,
  input  logic                ub_rd_gnt,
  input  logic                ub_rd_valid,
  input  logic [4*DATA_W-1:0] ub_rd_data,
  output logic [3:0]          vpu_data_pathway,
  output logic [DATA_W-1:0]   bias_scalar_out_1,
  output logic [DATA_W-1:0]   bias_scalar_out_2,
  output logic [DATA_W-1:0]   bias_scalar_out_3,
  output logic [DATA_W-1:0]   bias_scalar_out_4,
  output logic [DATA_W-1:0]   lr_leak_factor_out,
  output logic                sa_start,
  input  logic                vpu_valid_out_1,
  input  logic                vpu_valid_out_2,
  input  logic                vpu_valid_out_3,
  input  logic                vpu_valid_out_4,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  seq_state_e                  state_q, state_d;
  logic [3:0]                  mode_q, mode_d;
  logic [ROW_W-1:0]            rows_q, rows_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [DATA_W-1:0]           leak_q, leak_d;
  logic [3:0][DATA_W-1:0]      bias_q, bias_d;
  logic [WD_W-1:0]             wd_q, wd_d, wd_inc;
  logic                        fin_err, run_phase;

  logic                        cmd_ready_q, busy_q, done_q, err_q, sa_start_q, req_q;
  logic [3:0]                  pathway_q;
  logic [DATA_W-1:0]           leak_out_q;

  logic [3:0]                  lane_valid, lane_reached;
  logic                        lane_clr, lane_en, any_valid, all_reached;

  assign lane_valid  = {vpu_valid_out_4, vpu_valid_out_3, vpu_valid_out_2, vpu_valid_out_1};
  assign lane_clr    = (state_q == S_FIN);
  assign lane_en     = (state_q == S_RUN);
  assign any_valid   = |lane_valid;
  assign all_reached = &lane_reached;
  assign wd_inc      = wd_q + 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      vpu_lane_ctr #(.ROW_W(ROW_W)) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (lane_clr),
        .en_i      (lane_en),
        .inc_i     (lane_valid[gi]),
        .target_i  (rows_q),
        .reached_o (lane_reached[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rows_d  = rows_q;
    addr_d  = addr_q;
    leak_d  = leak_q;
    bias_d  = bias_q;
    wd_d    = wd_q;
    fin_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          mode_d = cmd_mode;
          rows_d = cmd_rows;
          addr_d = cmd_bias_addr;
          leak_d = cmd_leak;
          if (!is_legal_mode(cmd_mode) || (cmd_rows == '0)) begin
            state_d = S_FIN;
            fin_err = 1'b1;
          end else if (cmd_mode[3]) begin
            state_d = S_FETCH_REQ;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_FETCH_REQ: begin
        if (ub_rd_gnt) begin
          if (ub_rd_valid) begin
            bias_d  = ub_rd_data;
            state_d = S_START;
          end else begin
            state_d = S_FETCH_WAIT;
          end
        end
      end
      S_FETCH_WAIT: begin
        if (ub_rd_valid) begin
          bias_d  = ub_rd_data;
          state_d = S_START;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        // Completion wins over a coincident watchdog expiry.
        if (all_reached) begin
          state_d = S_FIN;
        end else if (!any_valid && (wd_inc == WD_W'(TIMEOUT))) begin
          state_d = S_FIN;
          fin_err = 1'b1;
        end else begin
          wd_d = any_valid ? '0 : wd_inc;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        wd_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // Illegal commands jump IDLE->FIN and never expose their mode/leak.
    run_phase = (state_d == S_START) || (state_d == S_RUN) ||
                ((state_d == S_FIN) && (state_q != S_IDLE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      rows_q      <= '0;
      addr_q      <= '0;
      leak_q      <= '0;
      bias_q      <= '0;
      wd_q        <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sa_start_q  <= 1'b0;
      req_q       <= 1'b0;
      pathway_q   <= '0;
      leak_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      rows_q      <= rows_d;
      addr_q      <= addr_d;
      leak_q      <= leak_d;
      bias_q      <= bias_d;
      wd_q        <= wd_d;
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_FIN);
      err_q       <= (state_d == S_FIN) && fin_err;
      sa_start_q  <= (state_d == S_START);
      req_q       <= (state_d == S_FETCH_REQ);
      pathway_q   <= run_phase ? mode_d : 4'b0000;
      leak_out_q  <= run_phase ? leak_d : '0;
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign sa_start           = sa_start_q;
  assign ub_rd_req          = req_q;
  assign ub_rd_addr         = addr_q;
  assign vpu_data_pathway   = pathway_q;
  assign lr_leak_factor_out = leak_out_q;
  assign bias_scalar_out_1  = bias_q[0];
  assign bias_scalar_out_2  = bias_q[1];
  assign bias_scalar_out_3  = bias_q[2];
  assign bias_scalar_out_4  = bias_q[3];

endmodule

// File: tb/tb_vpu_seq.sv
// Scenario bench for vpu_seq: expected completions are queued when the last
// stimulus of a command is driven and matched against each done pulse.
module tb_vpu_seq;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_mode;
  logic [7:0]  cmd_rows;
  logic [7:0]  cmd_bias_addr;
  logic [15:0] cmd_leak;
  logic        ub_rd_req;
  logic [7:0]  ub_rd_addr;
  logic        ub_rd_gnt;
  logic        ub_rd_valid;
  logic [63:0] ub_rd_data;
  logic [3:0]  vpu_data_pathway;
  logic [15:0] bias_scalar_out_1, bias_scalar_out_2, bias_scalar_out_3, bias_scalar_out_4;
  logic [15:0] lr_leak_factor_out;
  logic        sa_start;
  logic        vpu_valid_out_1, vpu_valid_out_2, vpu_valid_out_3, vpu_valid_out_4;
  logic        busy, done, err;

  vpu_seq #(.DATA_W(16), .ADDR_W(8), .ROW_W(8), .TIMEOUT(5)) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_mode           (cmd_mode),
    .cmd_rows           (cmd_rows),
    .cmd_bias_addr      (cmd_bias_addr),
    .cmd_leak           (cmd_leak),
    .ub_rd_req          (ub_rd_req),
    .ub_rd_addr         (ub_rd_addr),
    .ub_rd_gnt          (ub_rd_gnt),
    .ub_rd_valid        (ub_rd_valid),
    .ub_rd_data         (ub_rd_data),
    .vpu_data_pathway   (vpu_data_pathway),
    .bias_scalar_out_1  (bias_scalar_out_1),
    .bias_scalar_out_2  (bias_scalar_out_2),
    .bias_scalar_out_3  (bias_scalar_out_3),
    .bias_scalar_out_4  (bias_scalar_out_4),
    .lr_leak_factor_out (lr_leak_factor_out),
    .sa_start           (sa_start),
    .vpu_valid_out_1    (vpu_valid_out_1),
    .vpu_valid_out_2    (vpu_valid_out_2),
    .vpu_valid_out_3    (vpu_valid_out_3),
    .vpu_valid_out_4    (vpu_valid_out_4),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  typedef struct {
    logic        err;
    logic [3:0]  path;
    logic [63:0] bias;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          sa_cnt = 0;
  int          req_cnt = 0;
  logic        done_prev = 1'b0;
  logic [63:0] bias_m = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (sa_start) sa_cnt++;
    if (ub_rd_req) req_cnt++;
    if (!rst && done) begin
      exp_t e;
      checks++;
      if (done_prev) begin
        errors++;
        $display("FAIL done_pulse: done high on consecutive cycles at cyc %0d, required single-cycle pulse", cyc);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done at cyc %0d err=%0b with no command outstanding", cyc, err);
      end else begin
        e = sb.pop_front();
        checks++;
        if (err !== e.err) begin
          errors++;
          $display("FAIL done_err: got %0b required %0b at cyc %0d", err, e.err, cyc);
        end
        checks++;
        if (vpu_data_pathway !== e.path) begin
          errors++;
          $display("FAIL done_pathway: got %b required %b", vpu_data_pathway, e.path);
        end
        checks++;
        if ({bias_scalar_out_4, bias_scalar_out_3, bias_scalar_out_2, bias_scalar_out_1} !== e.bias) begin
          errors++;
          $display("FAIL done_bias: got %h required %h",
                   {bias_scalar_out_4, bias_scalar_out_3, bias_scalar_out_2, bias_scalar_out_1}, e.bias);
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL done_latency: done at cyc %0d required cyc %0d", cyc, e.cyc);
        end
      end
    end
    done_prev = done && !rst;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] m, input logic [7:0] r, input logic [7:0] a,
                          input logic [15:0] l);
    cmd_valid     = 1'b1;
    cmd_mode      = m;
    cmd_rows      = r;
    cmd_bias_addr = a;
    cmd_leak      = l;
    step();
    cmd_valid     = 1'b0;
  endtask

  task automatic set_valids(input logic [3:0] v);
    vpu_valid_out_1 = v[0];
    vpu_valid_out_2 = v[1];
    vpu_valid_out_3 = v[2];
    vpu_valid_out_4 = v[3];
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({cmd_ready, busy, done, err, sa_start, ub_rd_req} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/busy/done/err/sa/req got %b required 100000",
               {cmd_ready, busy, done, err, sa_start, ub_rd_req});
    end
    checks++;
    if ({vpu_data_pathway, lr_leak_factor_out, ub_rd_addr} !== 28'h0) begin
      errors++;
      $display("FAIL reset_operands: pathway=%b leak=%h addr=%h required all 0",
               vpu_data_pathway, lr_leak_factor_out, ub_rd_addr);
    end
    checks++;
    if ({bias_scalar_out_4, bias_scalar_out_3, bias_scalar_out_2, bias_scalar_out_1} !== 64'h0) begin
      errors++;
      $display("FAIL reset_bias: got %h required 0",
               {bias_scalar_out_4, bias_scalar_out_3, bias_scalar_out_2, bias_scalar_out_1});
    end
    rst = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
    $display("reset: idle after release ready=%b busy=%b", cmd_ready, busy);
  endtask

  task automatic test_bias_lrelu();
    int sa0 = sa_cnt;
    bias_m = {16'd4, 16'd3, 16'd2, 16'd1};
    send_cmd(4'b1100, 8'd8, 8'h10, 16'h0033);
    checks++;
    if (ub_rd_req !== 1'b1 || ub_rd_addr !== 8'h10 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bl_fetch_req: req=%b addr=%h busy=%b ready=%b required 1/10/1/0",
               ub_rd_req, ub_rd_addr, busy, cmd_ready);
    end
    step();
    step();
    checks++;
    if (ub_rd_req !== 1'b1) begin
      errors++;
      $display("FAIL bl_req_hold: req=%b required 1 until grant", ub_rd_req);
    end
    ub_rd_gnt = 1'b1;
    step();
    ub_rd_gnt = 1'b0;
    checks++;
    if (ub_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL bl_req_drop: req=%b required 0 after grant", ub_rd_req);
    end
    ub_rd_valid = 1'b1;
    ub_rd_data  = bias_m;
    step();
    ub_rd_valid = 1'b0;
    ub_rd_data  = '0;
    checks++;
    if (sa_start !== 1'b1 || vpu_data_pathway !== 4'b1100) begin
      errors++;
      $display("FAIL bl_start: sa_start=%b pathway=%b required 1/1100", sa_start, vpu_data_pathway);
    end
    checks++;
    if ({bias_scalar_out_4, bias_scalar_out_3, bias_scalar_out_2, bias_scalar_out_1} !== bias_m) begin
      errors++;
      $display("FAIL bl_bias: got %h required %h",
               {bias_scalar_out_4, bias_scalar_out_3, bias_scalar_out_2, bias_scalar_out_1}, bias_m);
    end
    step();
    for (int t = 0; t < 11; t++) begin
      vpu_valid_out_1 = (t <= 7);
      vpu_valid_out_2 = (t >= 1 && t <= 8);
      vpu_valid_out_3 = (t >= 2 && t <= 9);
      vpu_valid_out_4 = (t >= 3);
      if (t == 5) begin
        checks++;
        if (vpu_data_pathway !== 4'b1100 || lr_leak_factor_out !== 16'h0033 || sa_start !== 1'b0) begin
          errors++;
          $display("FAIL bl_run: pathway=%b leak=%h sa_start=%b required 1100/0033/0",
                   vpu_data_pathway, lr_leak_factor_out, sa_start);
        end
      end
      if (t == 10) sb.push_back('{1'b0, 4'b1100, bias_m, cyc + 2});
      step();
    end
    set_valids(4'b0000);
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bl_drain: %0d completions outstanding, required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (sa_cnt - sa0 != 1) begin
      errors++;
      $display("FAIL bl_sa_count: %0d sa_start pulses, required 1", sa_cnt - sa0);
    end
    $display("bias_lrelu: rows=8 staggered lanes, sa pulses=%0d", sa_cnt - sa0);
  endtask

  task automatic test_lrelu();
    int sa0  = sa_cnt;
    int req0 = req_cnt;
    send_cmd(4'b0100, 8'd4, 8'h00, 16'h0100);
    checks++;
    if (sa_start !== 1'b1 || ub_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL lr_start: sa_start=%b req=%b required 1/0", sa_start, ub_rd_req);
    end
    step();
    for (int t = 0; t < 4; t++) begin
      set_valids(4'b1111);
      // Offered command while running must be ignored.
      cmd_valid = (t == 1);
      cmd_mode  = 4'b1010;
      if (t == 1) begin
        checks++;
        if (cmd_ready !== 1'b0 || lr_leak_factor_out !== 16'h0100) begin
          errors++;
          $display("FAIL lr_run: cmd_ready=%b leak=%h required 0/0100", cmd_ready, lr_leak_factor_out);
        end
      end
      if (t == 3) sb.push_back('{1'b0, 4'b0100, bias_m, cyc + 2});
      step();
    end
    cmd_valid = 1'b0;
    set_valids(4'b0000);
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL lr_drain: %0d completions outstanding, required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (req_cnt != req0 || sa_cnt - sa0 != 1) begin
      errors++;
      $display("FAIL lr_counts: req cycles=%0d sa pulses=%0d required 0/1", req_cnt - req0, sa_cnt - sa0);
    end
    $display("lrelu: rows=4 no fetch, bias held %h", bias_m);
  endtask

  task automatic test_illegal();
    int sa0  = sa_cnt;
    int req0 = req_cnt;
    sb.push_back('{1'b1, 4'b0000, bias_m, cyc + 1});
    send_cmd(4'b1010, 8'd5, 8'h20, 16'h0007);
    step();
    sb.push_back('{1'b1, 4'b0000, bias_m, cyc + 1});
    send_cmd(4'b1000, 8'd0, 8'h20, 16'h0007);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL il_drain: %0d completions outstanding, required 0", sb.size());
      sb.delete();
    end
    step();
    checks++;
    if (sa_cnt != sa0 || req_cnt != req0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL il_side_effects: sa=%0d req=%0d ready=%b required 0/0/1",
               sa_cnt - sa0, req_cnt - req0, cmd_ready);
    end
    $display("illegal: mode 1010 and rows=0 rejected with err");
  endtask

  task automatic test_timeout();
    bias_m = {16'd40, 16'd30, 16'd20, 16'd10};
    send_cmd(4'b1000, 8'd3, 8'h44, 16'h0000);
    ub_rd_gnt = 1'b1;
    step();
    ub_rd_gnt = 1'b0;
    step();
    ub_rd_valid = 1'b1;
    ub_rd_data  = bias_m;
    step();
    ub_rd_valid = 1'b0;
    step();
    for (int t = 0; t < 3; t++) begin
      vpu_valid_out_1 = 1'b1;
      vpu_valid_out_2 = 1'b1;
      vpu_valid_out_3 = (t < 2);
      vpu_valid_out_4 = 1'b1;
      if (t == 2) sb.push_back('{1'b1, 4'b1000, bias_m, cyc + 6});
      step();
    end
    set_valids(4'b0000);
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL to_drain: %0d completions outstanding, required 0", sb.size());
      sb.delete();
    end
    step();
    $display("timeout: lane3 short by one, abort with err");
  endtask

  task automatic test_reset_midfetch();
    send_cmd(4'b1100, 8'd2, 8'h22, 16'h0055);
    ub_rd_gnt = 1'b1;
    step();
    ub_rd_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, busy, done, err, sa_start, ub_rd_req} !== 6'b100000 || vpu_data_pathway !== 4'b0000) begin
      errors++;
      $display("FAIL rm_async: ready/busy/done/err/sa/req=%b pathway=%b required 100000/0000",
               {cmd_ready, busy, done, err, sa_start, ub_rd_req}, vpu_data_pathway);
    end
    checks++;
    if ({bias_scalar_out_4, bias_scalar_out_3, bias_scalar_out_2, bias_scalar_out_1} !== 64'h0) begin
      errors++;
      $display("FAIL rm_bias_clear: got %h required 0",
               {bias_scalar_out_4, bias_scalar_out_3, bias_scalar_out_2, bias_scalar_out_1});
    end
    step();
    rst    = 1'b0;
    bias_m = '0;
    ub_rd_valid = 1'b1;
    ub_rd_data  = 64'hFFFF_EEEE_DDDD_CCCC;
    step();
    ub_rd_valid = 1'b0;
    ub_rd_data  = '0;
    checks++;
    if ({bias_scalar_out_4, bias_scalar_out_3, bias_scalar_out_2, bias_scalar_out_1} !== 64'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rm_stale_resp: bias=%h busy=%b required 0/0",
               {bias_scalar_out_4, bias_scalar_out_3, bias_scalar_out_2, bias_scalar_out_1}, busy);
    end
    $display("reset_midfetch: stale UB response ignored");
  endtask

  task automatic test_gnt_valid_same();
    bias_m = {16'd8, 16'd7, 16'd6, 16'd5};
    send_cmd(4'b1000, 8'd8, 8'h30, 16'h0000);
    checks++;
    if (ub_rd_req !== 1'b1 || ub_rd_addr !== 8'h30) begin
      errors++;
      $display("FAIL gv_req: req=%b addr=%h required 1/30", ub_rd_req, ub_rd_addr);
    end
    ub_rd_gnt   = 1'b1;
    ub_rd_valid = 1'b1;
    ub_rd_data  = bias_m;
    step();
    ub_rd_gnt   = 1'b0;
    ub_rd_valid = 1'b0;
    ub_rd_data  = '0;
    checks++;
    if (sa_start !== 1'b1 || ub_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL gv_direct_start: sa_start=%b req=%b required 1/0", sa_start, ub_rd_req);
    end
    step();
    // Lane 1 runs ahead with 10 valids; it must saturate at 8 for the others to finish.
    for (int t = 0; t < 10; t++) begin
      vpu_valid_out_1 = 1'b1;
      vpu_valid_out_2 = (t >= 2);
      vpu_valid_out_3 = (t >= 2);
      vpu_valid_out_4 = (t >= 2);
      if (t == 9) sb.push_back('{1'b0, 4'b1000, bias_m, cyc + 2});
      step();
    end
    set_valids(4'b0000);
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL gv_drain: %0d completions outstanding, required 0", sb.size());
      sb.delete();
    end
    $display("gnt_valid_same: direct capture %h, lane1 saturated", bias_m);
  endtask

  initial begin
    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_mode      = '0;
    cmd_rows      = '0;
    cmd_bias_addr = '0;
    cmd_leak      = '0;
    ub_rd_gnt     = 1'b0;
    ub_rd_valid   = 1'b0;
    ub_rd_data    = '0;
    set_valids(4'b0000);
    test_reset();
    test_bias_lrelu();
    test_lrelu();
    test_illegal();
    test_timeout();
    test_reset_midfetch();
    test_gnt_valid_same();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
